// File: rtl/mips_core_pkg.sv
// Shared store-queue types: entry layout, default depth and the word-granular address compare.
// Pure declarations; no timing or flow control of its own.
package mips_core_pkg;

  localparam int SQ_DEPTH  = 8;
  localparam int SQ_ADDR_W = 32;
  localparam int SQ_DATA_W = 32;

  typedef struct packed {
    logic                 resolved;
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
  } sq_entry_t;

  // Stores and loads alias when they touch the same 32-bit word.
  function automatic logic word_match(input logic [SQ_ADDR_W-1:0] a,
                                      input logic [SQ_ADDR_W-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/sq_age_select.sv
// Age-ordered search of the older-store window [head, snap): youngest resolved match and any
// younger unresolved store. Purely combinational, no flow control.
module sq_age_select
  import mips_core_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match_i,
  input  logic [DEPTH-1:0] unres_i,
  input  logic [IDX_W:0]   head_i,
  input  logic [IDX_W:0]   snap_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             unres_younger_o
);

  logic [IDX_W:0]   span;
  logic [IDX_W-1:0] phys;
  logic [DEPTH-1:0] rot_match;
  logic [DEPTH-1:0] rot_unres;

  always_comb begin
    span      = snap_i - head_i;
    phys      = '0;
    rot_match = '0;
    rot_unres = '0;
    // Rotated slot k is the k-th oldest entry; a span beyond DEPTH means the snapshot already drained.
    for (int k = 0; k < DEPTH; k++) begin
      phys = head_i[IDX_W-1:0] + IDX_W'(k);
      if ((span <= (IDX_W+1)'(DEPTH)) && ((IDX_W+1)'(k) < span)) begin
        rot_match[k] = match_i[phys];
        rot_unres[k] = unres_i[phys];
      end
    end

    found_o         = 1'b0;
    idx_o           = '0;
    unres_younger_o = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!found_o) begin
        if (rot_match[k]) begin
          found_o = 1'b1;
          idx_o   = head_i[IDX_W-1:0] + IDX_W'(k);
        end else if (rot_unres[k]) begin
          unres_younger_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_queue_fwd.sv
// Age-ordered store queue: in-order alloc/commit/drain, 0-cycle load lookup, D-cache valid/ready drain.
// Define STORE_FWD_EN for store-to-load forwarding; otherwise any older alias or unresolved store stalls.
module store_queue_fwd
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = SQ_DEPTH,
  parameter int ADDR_W = SQ_ADDR_W,
  parameter int DATA_W = SQ_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [IDX_W:0]    alloc_ptr,
  input  logic              agu_valid,
  input  logic [IDX_W-1:0]  agu_idx,
  input  logic [ADDR_W-1:0] agu_addr,
  input  logic [DATA_W-1:0] agu_data,
  input  logic              commit_valid,
  input  logic              flush,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [IDX_W:0]    ld_snap,
  output logic              ld_fwd_hit,
  output logic [DATA_W-1:0] ld_fwd_data,
  output logic              ld_stall,
  output logic [IDX_W:0]    count,
  output logic              empty
);

  localparam logic [IDX_W:0] DEPTH_P = (IDX_W+1)'(DEPTH);

  sq_entry_t        entry_q [DEPTH];
  logic [IDX_W:0]   head_q, head_d;
  logic [IDX_W:0]   cmt_q, cmt_d;
  logic [IDX_W:0]   tail_q, tail_d;
  logic             full;
  logic             do_alloc, do_agu, do_commit, do_drain;
  logic [DEPTH-1:0] match_vec, unres_vec;

  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_P);
  assign alloc_ready = !full && !flush;
  assign alloc_ptr   = tail_q;

  assign do_alloc  = alloc_valid && alloc_ready;
  assign do_agu    = agu_valid && !flush;
  assign do_commit = commit_valid && (cmt_q != tail_q) && entry_q[cmt_q[IDX_W-1:0]].resolved;

  assign dc_req_valid = (head_q != cmt_q) && entry_q[head_q[IDX_W-1:0]].resolved;
  assign dc_req_addr  = dc_req_valid ? entry_q[head_q[IDX_W-1:0]].addr : '0;
  assign dc_req_data  = dc_req_valid ? entry_q[head_q[IDX_W-1:0]].data : '0;
  assign do_drain     = dc_req_valid && dc_req_ready;

  // Flush rewinds tail onto the commit pointer after this cycle's commit has advanced it.
  always_comb begin
    head_d = head_q + (IDX_W+1)'(do_drain);
    cmt_d  = cmt_q + (IDX_W+1)'(do_commit);
    tail_d = flush ? cmt_d : tail_q + (IDX_W+1)'(do_alloc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      if (do_alloc) entry_q[tail_q[IDX_W-1:0]].resolved <= 1'b0;
      if (do_agu)   entry_q[agu_idx] <= '{resolved: 1'b1, addr: agu_addr, data: agu_data};
    end
  end

  always_comb begin
    match_vec = '0;
    unres_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = entry_q[i].resolved && word_match(entry_q[i].addr, ld_addr);
      unres_vec[i] = !entry_q[i].resolved;
    end
  end

`ifdef STORE_FWD_EN
  logic             m_found;
  logic             m_unres_younger;
  logic [IDX_W-1:0] m_idx;

  sq_age_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_age_select (
    .match_i         (match_vec),
    .unres_i         (unres_vec),
    .head_i          (head_q),
    .snap_i          (ld_snap),
    .found_o         (m_found),
    .idx_o           (m_idx),
    .unres_younger_o (m_unres_younger)
  );

  assign ld_fwd_hit  = ld_valid && m_found && !m_unres_younger;
  assign ld_stall    = ld_valid && m_unres_younger;
  assign ld_fwd_data = ld_fwd_hit ? entry_q[m_idx].data : '0;
`else
  logic [IDX_W:0]   ld_span;
  logic [IDX_W-1:0] rel;
  logic [DEPTH-1:0] older_vec;

  always_comb begin
    ld_span   = ld_snap - head_q;
    rel       = '0;
    older_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = IDX_W'(i) - head_q[IDX_W-1:0];
      older_vec[i] = (ld_span <= DEPTH_P) && ({1'b0, rel} < ld_span);
    end
  end

  assign ld_stall    = ld_valid && |(older_vec & (unres_vec | match_vec));
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_queue_fwd.sv
// Bench for store_queue_fwd: directed scenarios plus random traffic against a sequence-numbered store model.
module tb_store_queue_fwd;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;
  localparam int PM    = 2 * DEPTH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_valid, alloc_ready;
  logic [IDX_W:0]    alloc_ptr;
  logic              agu_valid;
  logic [IDX_W-1:0]  agu_idx;
  logic [31:0]       agu_addr, agu_data;
  logic              commit_valid, flush;
  logic              dc_req_valid, dc_req_ready;
  logic [31:0]       dc_req_addr, dc_req_data;
  logic              ld_valid;
  logic [31:0]       ld_addr;
  logic [IDX_W:0]    ld_snap;
  logic              ld_fwd_hit, ld_stall;
  logic [31:0]       ld_fwd_data;
  logic [IDX_W:0]    count;
  logic              empty;

  store_queue_fwd #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .agu_valid(agu_valid), .agu_idx(agu_idx), .agu_addr(agu_addr), .agu_data(agu_data),
    .commit_valid(commit_valid), .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_snap(ld_snap),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: stores numbered by absolute age; head/commit/tail are plain counters.
  int          h_n, c_n, t_n, agu_seq, ld_seq;
  bit          m_res [int];
  logic [31:0] m_addr [int];
  logic [31:0] m_data [int];
  logic        e_hit, e_stall, e_dcv;
  logic [31:0] e_fd, e_da, e_dd;
  logic [31:0] pool [4] = '{32'h100, 32'h102, 32'h104, 32'h200};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [IDX_W:0] ptr(input int s);
    return (IDX_W+1)'(s % PM);
  endfunction

  task automatic model_eval();
    bit u, m;
    logic [31:0] d;
    u = 0; m = 0; d = '0;
    for (int k = ld_seq - 1; k >= h_n; k--) begin
      if (!m_res[k]) begin u = 1; break; end
      if (m_addr[k][31:2] == ld_addr[31:2]) begin m = 1; d = m_data[k]; break; end
    end
    e_dcv = (h_n < c_n) && m_res[h_n];
    e_da  = e_dcv ? m_addr[h_n] : '0;
    e_dd  = e_dcv ? m_data[h_n] : '0;
`ifdef STORE_FWD_EN
    e_hit   = ld_valid && m;
    e_stall = ld_valid && u;
    e_fd    = e_hit ? d : '0;
`else
    e_hit   = 1'b0;
    e_stall = ld_valid && (u || m);
    e_fd    = '0;
`endif
  endtask

  task automatic idle();
    alloc_valid = 0; agu_valid = 0; agu_idx = '0; agu_addr = '0; agu_data = '0;
    commit_valid = 0; flush = 0; dc_req_ready = 0;
    ld_valid = 0; ld_addr = '0; ld_seq = t_n; ld_snap = ptr(t_n);
  endtask

  // Inputs are already driven (just after negedge); check, advance the model, move to next negedge.
  task automatic cycle();
    int cnt;
    bit ready_e, do_commit;
    #1;
    model_eval();
    cnt       = t_n - h_n;
    ready_e   = (cnt < DEPTH) && !flush;
    do_commit = commit_valid && (c_n < t_n) && m_res[c_n];
    chk("count", count, cnt);
    chk("empty", empty, cnt == 0);
    chk("alloc_ready", alloc_ready, ready_e);
    chk("alloc_ptr", alloc_ptr, ptr(t_n));
    chk("dc_req_valid", dc_req_valid, e_dcv);
    chk("dc_req_addr", dc_req_addr, e_da);
    chk("dc_req_data", dc_req_data, e_dd);
    chk("ld_fwd_hit", ld_fwd_hit, e_hit);
    chk("ld_fwd_data", ld_fwd_data, e_fd);
    chk("ld_stall", ld_stall, e_stall);
    if (commit_valid) assert (do_commit) else $error("illegal commit stimulus");
    if (agu_valid && !flush) begin
      m_res[agu_seq] = 1; m_addr[agu_seq] = agu_addr; m_data[agu_seq] = agu_data;
    end
    if (alloc_valid && ready_e) begin m_res[t_n] = 0; t_n++; end
    if (e_dcv && dc_req_ready) h_n++;
    if (do_commit) c_n++;
    if (flush) t_n = c_n;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    h_n = 0; c_n = 0; t_n = 0;
    m_res.delete(); m_addr.delete(); m_data.delete();
    ld_seq = 0; ld_snap = '0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dc_valid", dc_req_valid, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_ptr", alloc_ptr, 0);
    chk("rst_fwd_hit", ld_fwd_hit, 0);
    chk("rst_stall", ld_stall, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic allocs(input int n);
    for (int i = 0; i < n; i++) begin idle(); alloc_valid = 1; cycle(); end
  endtask

  task automatic agu(input int s, input logic [31:0] a, input logic [31:0] d);
    idle(); agu_valid = 1; agu_seq = s; agu_idx = IDX_W'(s % DEPTH);
    agu_addr = a; agu_data = d;
    cycle();
  endtask

  task automatic commits(input int n);
    for (int i = 0; i < n; i++) begin idle(); commit_valid = 1; cycle(); end
  endtask

  task automatic load_probe(input int s, input logic [31:0] a);
    idle(); ld_valid = 1; ld_addr = a; ld_seq = s; ld_snap = ptr(s);
    #1;
  endtask

  task automatic rand_in();
    int q[$];
    int lo;
    idle();
    alloc_valid = 1'($urandom_range(0, 1));
    for (int s = h_n; s < t_n; s++) if (!m_res[s]) q.push_back(s);
    if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
      agu_seq   = q[$urandom_range(0, q.size() - 1)];
      agu_valid = 1; agu_idx = IDX_W'(agu_seq % DEPTH);
      agu_addr  = pool[$urandom_range(0, 3)]; agu_data = $urandom;
    end
    commit_valid = (c_n < t_n) && m_res[c_n] && ($urandom_range(0, 1) == 1);
    flush        = ($urandom_range(0, 19) == 0);
    dc_req_ready = ($urandom_range(0, 3) != 0);
    ld_valid     = 1'($urandom_range(0, 1));
    ld_addr      = pool[$urandom_range(0, 3)];
    lo           = (h_n > 2) ? h_n - 2 : 0;
    ld_seq       = lo + int'($urandom_range(0, t_n - lo));
    ld_snap      = ptr(ld_seq);
  endtask

  initial begin
    idle();
    h_n = 0; c_n = 0; t_n = 0;
    @(negedge clk);
    do_reset();

    // Fill to DEPTH, then a refused alloc leaves tail alone.
    allocs(8);
    idle(); #1;
    chk("full_count", count, 8);
    chk("full_alloc_ready", alloc_ready, 0);
    alloc_valid = 1; cycle();
    idle(); #1;
    chk("full_tail_held", alloc_ptr, 4'h8);

    // Single resolved store forwarding, then a snapshot that excludes it.
    do_reset();
    allocs(1);
    agu(0, 32'h100, 32'hDEAD);
    load_probe(1, 32'h100);
`ifdef STORE_FWD_EN
    chk("fwd1_hit", ld_fwd_hit, 1);
    chk("fwd1_data", ld_fwd_data, 32'hDEAD);
    chk("fwd1_stall", ld_stall, 0);
`else
    chk("nofwd1_stall", ld_stall, 1);
    chk("nofwd1_hit", ld_fwd_hit, 0);
`endif
    cycle();
    load_probe(0, 32'h100);
    chk("snap0_hit", ld_fwd_hit, 0);
    chk("snap0_stall", ld_stall, 0);
    cycle();

    // Two aliasing stores: youngest wins; an unresolved younger one stalls.
    do_reset();
    allocs(2);
    agu(0, 32'h100, 32'h11);
    agu(1, 32'h100, 32'h22);
    load_probe(2, 32'h100);
`ifdef STORE_FWD_EN
    chk("fwd2_data", ld_fwd_data, 32'h22);
`else
    chk("nofwd2_stall", ld_stall, 1);
`endif
    cycle();
    do_reset();
    allocs(2);
    agu(0, 32'h100, 32'h11);
    load_probe(2, 32'h100);
    chk("unres_stall", ld_stall, 1);
    chk("unres_hit", ld_fwd_hit, 0);
    cycle();

    // Commit 2 of 4, flush, drain with ready 1,0,1.
    do_reset();
    allocs(4);
    for (int s = 0; s < 4; s++) agu(s, 32'h400 + 32'(4 * s), 32'(s + 1));
    commits(2);
    idle(); flush = 1; cycle();
    idle(); #1;
    chk("flush_tail", alloc_ptr, 2);
    chk("flush_count", count, 2);
    idle(); dc_req_ready = 1; cycle();
    idle(); dc_req_ready = 0; cycle();
    idle(); dc_req_ready = 1; cycle();
    idle(); #1;
    chk("drained_dc_valid", dc_req_valid, 0);
    chk("drained_empty", empty, 1);

    // 13 stores through the queue, then an older window spanning index 7 -> 0.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      allocs(1);
      agu(i, 32'h300 + 32'(4 * i), 32'(i));
      commits(1);
      idle(); dc_req_ready = 1; cycle();
    end
    allocs(5);
    agu(13, 32'h600, 32'h1);
    agu(14, 32'h500, 32'hAAAA);
    agu(15, 32'h604, 32'h2);
    agu(16, 32'h500, 32'hBBBB);
    load_probe(17, 32'h500);
`ifdef STORE_FWD_EN
    chk("wrap_hit", ld_fwd_hit, 1);
    chk("wrap_data", ld_fwd_data, 32'hBBBB);
`else
    chk("wrap_stall", ld_stall, 1);
`endif
    cycle();
    load_probe(18, 32'h500);
    chk("wrap_unres_stall", ld_stall, 1);
    cycle();

    // Reset discards committed but undrained stores.
    do_reset();
    allocs(3);
    for (int s = 0; s < 3; s++) agu(s, 32'h700 + 32'(4 * s), 32'(s));
    commits(3);
    idle(); #1;
    chk("pre_rst_dc_valid", dc_req_valid, 1);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      rand_in();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
